// File: rtl/branch_cond_unit_pkg.sv
// Shared definitions for the ID-stage branch resolver: condition codes, flag
// bit positions (common with the flag register) and FSM state encoding.
package branch_cond_unit_pkg;

  localparam logic [2:0] COND_NE  = 3'b000;
  localparam logic [2:0] COND_EQ  = 3'b001;
  localparam logic [2:0] COND_GT  = 3'b010;
  localparam logic [2:0] COND_LT  = 3'b011;
  localparam logic [2:0] COND_GE  = 3'b100;
  localparam logic [2:0] COND_LE  = 3'b101;
  localparam logic [2:0] COND_OVF = 3'b110;
  localparam logic [2:0] COND_UNC = 3'b111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } bcu_state_t;

  // Saturating event counter step.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/branch_cond_unit_if.sv
// ID-stage <-> branch resolver bus. Stat signals exist only when
// BRANCH_STATS_EN is defined.
interface branch_cond_unit_if #(
  parameter int ADDR_W = 16
) ();
  // Handshake: the pipeline holds br_valid and its operands stable while
  // stall=1; a branch is consumed in the cycle br_valid=1, stall=0, kill=0.
  logic              br_valid;
  logic [2:0]        br_cond;
  logic [ADDR_W-1:0] br_target;
  logic [2:0]        ex_flag_wen;
  logic [2:0]        flags;
  logic              kill;
  logic              stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_redirect_pc;
  logic              br_done;
`ifdef BRANCH_STATS_EN
  logic [15:0]       stat_resolved;
  logic [15:0]       stat_taken;
  logic [15:0]       stat_stall;
`endif

  modport master (
    output br_valid, br_cond, br_target, ex_flag_wen, flags, kill,
    input  stall, br_taken, br_redirect_pc, br_done
`ifdef BRANCH_STATS_EN
    , input stat_resolved, stat_taken, stat_stall
`endif
  );

  modport slave (
    input  br_valid, br_cond, br_target, ex_flag_wen, flags, kill,
    output stall, br_taken, br_redirect_pc, br_done
`ifdef BRANCH_STATS_EN
    , output stat_resolved, stat_taken, stat_stall
`endif
  );
endinterface

// File: rtl/branch_cond_unit_cond_eval.sv
// Condition evaluator: result of a condition code against {Z,V,N} and the
// mask of flags that condition depends on (used for hazard detection).
module branch_cond_unit_cond_eval
  import branch_cond_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       result,
  output logic [2:0] read_mask
);

  always_comb begin
    result    = 1'b0;
    read_mask = 3'b000;
    case (cond)
      COND_NE: begin
        result            = !flags[FLAG_Z];
        read_mask[FLAG_Z] = 1'b1;
      end
      COND_EQ: begin
        result            = flags[FLAG_Z];
        read_mask[FLAG_Z] = 1'b1;
      end
      COND_GT: begin
        result            = !flags[FLAG_Z] && !flags[FLAG_N];
        read_mask[FLAG_Z] = 1'b1;
        read_mask[FLAG_N] = 1'b1;
      end
      COND_LT: begin
        result            = flags[FLAG_N];
        read_mask[FLAG_N] = 1'b1;
      end
      COND_GE: begin
        result            = flags[FLAG_Z] || !flags[FLAG_N];
        read_mask[FLAG_Z] = 1'b1;
        read_mask[FLAG_N] = 1'b1;
      end
      COND_LE: begin
        result            = flags[FLAG_Z] || flags[FLAG_N];
        read_mask[FLAG_Z] = 1'b1;
        read_mask[FLAG_N] = 1'b1;
      end
      COND_OVF: begin
        result            = flags[FLAG_V];
        read_mask[FLAG_V] = 1'b1;
      end
      COND_UNC: begin
        result = 1'b1;
      end
      default: begin
        result    = 1'b0;
        read_mask = 3'b000;
      end
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// ID-stage branch resolver: stalls on pending EX flag writes, then issues a
// registered one-cycle redirect. Optional counters under BRANCH_STATS_EN.
module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int STALL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  branch_cond_unit_if.slave bus,
  output bcu_state_t        state_dbg
);

  localparam logic [1:0] CNT_LOAD = 2'(STALL_CYCLES - 1);

  bcu_state_t        state;
  logic [1:0]        cnt;
  logic              cond_res;
  logic [2:0]        read_mask;
  logic              live;
  logic              hz;
  logic              stall_c;
  logic              resolve;
  logic              taken_q;
  logic              done_q;
  logic [ADDR_W-1:0] pc_q;

  branch_cond_unit_cond_eval u_cond_eval (
    .cond      (bus.br_cond),
    .flags     (bus.flags),
    .result    (cond_res),
    .read_mask (read_mask)
  );

  assign live = bus.br_valid && !bus.kill;
  assign hz   = live && |(bus.ex_flag_wen & read_mask);

  // In WAIT the EX stage holds a bubble, so ex_flag_wen is not consulted.
  always_comb begin
    stall_c = 1'b0;
    resolve = 1'b0;
    if (rst) begin
      case (state)
        ST_IDLE: begin
          stall_c = hz;
          resolve = live && !hz;
        end
        ST_WAIT: begin
          if (!bus.kill) begin
            if (cnt != 2'd0) stall_c = 1'b1;
            else             resolve = 1'b1;
          end
        end
        default: begin
          stall_c = 1'b0;
          resolve = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= 2'd0;
      taken_q <= 1'b0;
      done_q  <= 1'b0;
      pc_q    <= '0;
    end else begin
      done_q  <= resolve;
      taken_q <= resolve && cond_res;
      if (resolve && cond_res) pc_q <= bus.br_target;
      case (state)
        ST_IDLE: begin
          if (hz) begin
            cnt   <= CNT_LOAD;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.kill)             state <= ST_IDLE;
          else if (cnt != 2'd0)     cnt   <= cnt - 2'd1;
          else                      state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.stall          = stall_c;
  assign bus.br_taken       = taken_q;
  assign bus.br_done        = done_q;
  assign bus.br_redirect_pc = pc_q;
  assign state_dbg          = state;

`ifdef BRANCH_STATS_EN
  logic [15:0] stat_resolved_q;
  logic [15:0] stat_taken_q;
  logic [15:0] stat_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_resolved_q <= 16'd0;
      stat_taken_q    <= 16'd0;
      stat_stall_q    <= 16'd0;
    end else begin
      stat_resolved_q <= sat_inc16(stat_resolved_q, done_q);
      stat_taken_q    <= sat_inc16(stat_taken_q, taken_q);
      stat_stall_q    <= sat_inc16(stat_stall_q, stall_c);
    end
  end

  assign bus.stat_resolved = stat_resolved_q;
  assign bus.stat_taken    = stat_taken_q;
  assign bus.stat_stall    = stat_stall_q;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit (STALL_CYCLES=2): table of single-cycle resolves,
// hand sequences for stall/kill/reset, scoreboard of expected redirect pulses.
module tb_branch_cond_unit;
  import branch_cond_unit_pkg::*;

  localparam int AW = 16;

  logic       clk;
  logic       rst_n;
  bcu_state_t state_dbg;
  int         errors;
  int         checks;
  int         cyc;
  logic [AW-1:0] last_pc;
  int         n_resolved;
  int         n_taken;
  int         n_stall;

  // {cycle stamp[48:17], taken[16], pc[15:0]}
  logic [48:0] exp_q[$];

  typedef struct {
    logic [2:0]    flags;
    logic [2:0]    cond;
    logic [AW-1:0] target;
    logic [2:0]    wen;
    logic          exp_taken;
  } vec_t;

  vec_t vecs[16];

  branch_cond_unit_if #(.ADDR_W(AW)) bus ();

  branch_cond_unit #(.ADDR_W(AW), .STALL_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // One cycle: apply inputs at the negedge, check stall, predict the pulse.
  task automatic drive(input logic v, input logic [2:0] c, input logic [AW-1:0] t,
                       input logic [2:0] w, input logic [2:0] f, input logic k,
                       input logic exp_stall, input logic exp_res, input logic exp_tk,
                       input string name);
    logic [AW-1:0] pc;
    bus.br_valid    = v;
    bus.br_cond     = c;
    bus.br_target   = t;
    bus.ex_flag_wen = w;
    bus.flags       = f;
    bus.kill        = k;
    #1;
    chk({name, " stall"}, 32'(bus.stall), 32'(exp_stall));
    if (exp_stall) n_stall++;
    if (exp_res) begin
      pc = exp_tk ? t : last_pc;
      last_pc = pc;
      n_resolved++;
      if (exp_tk) n_taken++;
      exp_q.push_back({32'(cyc + 1), exp_tk, pc});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, COND_UNC, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  // scoreboard: every br_done must match the head of exp_q
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus.br_done) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse: unexpected br_done at cycle %0d taken=%b pc=%0h",
                   cyc, bus.br_taken, bus.br_redirect_pc);
        end else begin
          logic [48:0] e;
          e = exp_q.pop_front();
          if (int'(e[48:17]) != cyc || bus.br_taken !== e[16] || bus.br_redirect_pc !== e[15:0]) begin
            errors++;
            $display("FAIL pulse: got cyc=%0d taken=%b pc=%0h want cyc=%0d taken=%b pc=%0h",
                     cyc, bus.br_taken, bus.br_redirect_pc, int'(e[48:17]), e[16], e[15:0]);
          end
        end
      end else if (bus.br_taken !== 1'b0) begin
        errors++;
        $display("FAIL taken_without_done: got br_taken=%b want 0 at cycle %0d", bus.br_taken, cyc);
      end
    end
  end

  initial begin
    errors = 0; checks = 0; last_pc = '0;
    n_resolved = 0; n_taken = 0; n_stall = 0;

    vecs[0]  = '{3'b100, COND_EQ,  16'h0040, 3'b000, 1'b1};
    vecs[1]  = '{3'b000, COND_OVF, 16'h0041, 3'b100, 1'b0};
    vecs[2]  = '{3'b000, COND_NE,  16'h0100, 3'b000, 1'b1};
    vecs[3]  = '{3'b100, COND_NE,  16'h0101, 3'b000, 1'b0};
    vecs[4]  = '{3'b000, COND_GT,  16'h0102, 3'b010, 1'b1};
    vecs[5]  = '{3'b001, COND_GT,  16'h0103, 3'b000, 1'b0};
    vecs[6]  = '{3'b001, COND_LT,  16'h0104, 3'b100, 1'b1};
    vecs[7]  = '{3'b000, COND_LT,  16'h0105, 3'b010, 1'b0};
    vecs[8]  = '{3'b000, COND_GE,  16'h0106, 3'b000, 1'b1};
    vecs[9]  = '{3'b001, COND_GE,  16'h0107, 3'b000, 1'b0};
    vecs[10] = '{3'b101, COND_GE,  16'h0108, 3'b000, 1'b1};
    vecs[11] = '{3'b000, COND_LE,  16'h0109, 3'b000, 1'b0};
    vecs[12] = '{3'b001, COND_LE,  16'h010A, 3'b000, 1'b1};
    vecs[13] = '{3'b010, COND_OVF, 16'h010B, 3'b101, 1'b1};
    vecs[14] = '{3'b101, COND_OVF, 16'h010C, 3'b000, 1'b0};
    vecs[15] = '{3'b000, COND_UNC, 16'h010D, 3'b111, 1'b1};

    // reset held with a hazardous branch present
    rst_n = 1'b0;
    bus.br_valid = 1'b1; bus.br_cond = COND_EQ; bus.br_target = 16'h1234;
    bus.ex_flag_wen = 3'b100; bus.flags = 3'b000; bus.kill = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst stall", 32'(bus.stall), 32'd0);
    chk("rst taken", 32'(bus.br_taken), 32'd0);
    chk("rst done", 32'(bus.br_done), 32'd0);
    chk("rst pc", 32'(bus.br_redirect_pc), 32'd0);
    chk("rst state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // single-cycle resolves, back to back
    for (int i = 0; i < 16; i++)
      drive(1'b1, vecs[i].cond, vecs[i].target, vecs[i].wen, vecs[i].flags, 1'b0,
            1'b0, 1'b1, vecs[i].exp_taken, $sformatf("vec%0d", i));
    idle(2);

    // LT stalls on N write for 2 cycles; N becomes 1 during the stall
    drive(1'b1, COND_LT, 16'h0200, 3'b001, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, "lt_hz0");
    chk("lt state", 32'(state_dbg), 32'(ST_WAIT));
    drive(1'b1, COND_LT, 16'h0200, 3'b000, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, "lt_hz1");
    drive(1'b1, COND_LT, 16'h0200, 3'b001, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, "lt_res");
    idle(2);

    // kill during WAIT, then a clean branch
    drive(1'b1, COND_EQ, 16'h0300, 3'b100, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, "kw_hz");
    drive(1'b1, COND_EQ, 16'h0300, 3'b000, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, "kw_kill");
    drive(1'b1, COND_UNC, 16'h0077, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, "kw_next");
    idle(2);

    // kill on the would-be resolution cycle
    drive(1'b1, COND_GE, 16'h0400, 3'b001, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, "kr_hz0");
    drive(1'b1, COND_GE, 16'h0400, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, "kr_hz1");
    drive(1'b1, COND_GE, 16'h0400, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, "kr_kill");
    // kill in IDLE, with and without a pending flag write
    drive(1'b1, COND_UNC, 16'h0500, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, "ki_nohz");
    drive(1'b1, COND_EQ, 16'h0500, 3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, "ki_hz");
    idle(2);

    // consecutive unconditional branches
    drive(1'b1, COND_UNC, 16'h0010, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, "unc0");
    drive(1'b1, COND_UNC, 16'h0020, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, "unc1");
    idle(2);

    // taken then not-taken: pc must hold 0x0020 on the not-taken pulse
    drive(1'b1, COND_NE, 16'h0600, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, "hold_pc");
    idle(2);

`ifdef BRANCH_STATS_EN
    chk("stat_resolved", 32'(bus.stat_resolved), 32'(n_resolved));
    chk("stat_taken", 32'(bus.stat_taken), 32'(n_taken));
    chk("stat_stall", 32'(bus.stat_stall), 32'(n_stall));
`endif

    // asynchronous reset in the middle of WAIT
    drive(1'b1, COND_EQ, 16'h0700, 3'b100, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, "mr_hz");
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr stall", 32'(bus.stall), 32'd0);
    chk("mr taken", 32'(bus.br_taken), 32'd0);
    chk("mr done", 32'(bus.br_done), 32'd0);
    chk("mr pc", 32'(bus.br_redirect_pc), 32'd0);
    chk("mr state", 32'(state_dbg), 32'(ST_IDLE));
    last_pc = '0; n_resolved = 0; n_taken = 0; n_stall = 0;
    @(negedge clk);
    bus.br_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr idle", 32'(state_dbg), 32'(ST_IDLE));
    drive(1'b1, COND_EQ, 16'h0800, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, "mr_after");
    idle(2);

`ifdef BRANCH_STATS_EN
    chk("stat_after_rst", 32'(bus.stat_taken), 32'd1);
    for (int i = 0; i < 65536; i++)
      drive(1'b1, COND_UNC, AW'($urandom_range(0, 16'hFFFF)), 3'($urandom_range(0, 7)),
            3'b000, 1'b0, 1'b0, 1'b1, 1'b1, "sat");
    idle(3);
    chk("stat_taken_sat", 32'(bus.stat_taken), 32'hFFFF);
    chk("stat_resolved_sat", 32'(bus.stat_resolved), 32'hFFFF);
    chk("stat_stall_final", 32'(bus.stat_stall), 32'(n_stall));
`endif

    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d outstanding want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
- ID-stage branch resolver; the consumer of the Z/V/N flag register.
- Evaluates a 3-bit condition code against the architectural flags.
- Stalls ID while an in-flight EX instruction is still writing a flag that the condition reads.
- Issues a one-cycle registered redirect (taken + target) to the fetch stage.

Parameters:
- ADDR_W, 16, width of branch target / redirect PC.
- STALL_CYCLES, 1, cycles between a flag write in EX and that value being visible on flags; legal 1..3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- br_valid  in  1  branch instruction present in ID; held by the pipeline while stall=1.
- br_cond  in  3  condition code.
- br_target  in  ADDR_W  resolved target address.
- ex_flag_wen  in  3  EX-stage flag write enables {Z,V,N}, same bit order as the flag register.
- flags  in  3  current flags {Z,V,N} from the flag register.
- kill  in  1  squash the ID instruction (older redirect or exception).
- stall  out  1  freeze IF/ID; combinational.
- br_taken  out  1  registered one-cycle redirect pulse; also flushes IF/ID.
- br_redirect_pc  out  ADDR_W  registered target, valid when br_taken=1.
- br_done  out  1  registered one-cycle pulse per resolved branch, taken or not.

Behaviour:
- Condition codes:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | !N
  - 101 LE: Z | N
  - 110 OVF: V
  - 111 UNC: 1
- Flags read per code:
  - NE/EQ read Z.
  - GT/GE/LE read Z,N.
  - LT reads N.
  - OVF reads V.
  - UNC reads none.
- Hazard: hz = br_valid & !kill & |(ex_flag_wen & reads(br_cond)). A write to a flag the condition does not read never stalls.
- FSM states IDLE, WAIT; 2-bit counter cnt.
- IDLE:
  - hz=1: stall=1, cnt<=STALL_CYCLES-1, go to WAIT.
  - br_valid & !kill & !hz: resolve this cycle (cycle R), stay in IDLE.
  - Otherwise idle, stall=0.
- WAIT:
  - kill=1: stall=0, go to IDLE, no resolution.
  - cnt!=0: stall=1, cnt decrements.
  - cnt==0: stall=0, resolve using flags, go to IDLE.
  - ex_flag_wen is ignored in WAIT (EX holds a bubble).
- Total stall length for a hazard is exactly STALL_CYCLES cycles.
- Resolution in cycle R; in cycle R+1, for exactly one cycle:
  - br_done=1.
  - br_taken = cond result.
  - br_redirect_pc = br_target sampled in R; holds its last value when br_taken=0.
- Back-to-back branches in R and R+1 each produce their own pulse in R+1 and R+2.
- kill in the same cycle as a would-be resolution suppresses it; pulses already registered still fire.
- Reset (asynchronous, any state): state=IDLE, cnt=0, br_taken=0, br_done=0, br_redirect_pc=0, stats=0. stall=0 while reset is asserted.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - Adds outputs stat_resolved[15:0], stat_taken[15:0], stat_stall[15:0], each reset to 0.
  - stat_resolved increments on each br_done, stat_taken on each br_taken, stat_stall on each cycle with stall=1.
  - All three saturate at 16'hFFFF.
- Undefined: ports and counters are absent; core behaviour is identical.

Decomposition:
- Shared package holds:
  - Condition-code constants COND_NE..COND_UNC.
  - Flag bit indices FLAG_Z=2, FLAG_V=1, FLAG_N=0, shared with the flag register.
  - FSM state encodings.
- One sub-module, cond_eval: combinational, takes (cond, flags) and returns (result, read_mask). It is reused by hazard detection and resolution.

Test Plan:
- flags=100, br_cond=001, br_target=0x0040, ex_flag_wen=000, br_valid 1 cycle -> no stall; next cycle br_taken=1, br_redirect_pc=0x0040, br_done=1.
- flags=000, br_cond=110, ex_flag_wen=100 (Z only) -> no stall (OVF reads V only); br_done=1, br_taken=0 next cycle.
- STALL_CYCLES=2, br_cond=011, ex_flag_wen=001, flags changes to 001 during the stall -> stall high exactly 2 cycles; resolves with N=1 -> br_taken=1 one cycle later.
- Hazard stall in WAIT with kill asserted on the second cycle -> stall drops that cycle, no br_done/br_taken; the next branch resolves normally.
- Branches with cond 111 on two consecutive cycles, targets 0x0010, 0x0020 -> br_taken pulses in consecutive cycles carrying 0x0010 then 0x0020.
- rst asserted low mid-WAIT -> stall=0 and all outputs 0 immediately; after release, the FSM is in IDLE. Under BRANCH_STATS_EN, 0x10000 taken branches -> stat_taken=0xFFFF.
